// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: address field layout, block geometry and FSM encoding shared by the instruction cache
package instr_cache_pkg;

    localparam int ADDR_W   = 10;
    localparam int TAG_W    = 3;
    localparam int IDX_W    = 3;
    localparam int WSEL_W   = 2;
    localparam int TAG_LSB  = 7;
    localparam int IDX_LSB  = 4;
    localparam int WSEL_LSB = 2;
    localparam int SETS     = 1 << IDX_W;
    localparam int WORD_W   = 32;
    localparam int BLOCK_W  = 128;
    localparam int BADDR_W  = ADDR_W - IDX_LSB;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    // Word 0 of a block sits in the least significant 32 bits.
    function automatic logic [WORD_W-1:0] sel_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [WSEL_W-1:0]  w);
        return blk[WORD_W*w +: WORD_W];
    endfunction

endpackage

// File: rtl/instr_cache_array.sv
// instr_cache_array: direct-mapped valid/tag/data storage with one combinational lookup and one write port
module instr_cache_array
    import instr_cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [IDX_W-1:0]   rd_idx_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    output logic               match_o,
    output logic [BLOCK_W-1:0] rd_data_o,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i
);

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];

    // Valid bits are the only storage cleared by reset; a fill marks its set valid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) valid_q <= '0;
        else if (we_i) valid_q[wr_idx_i] <= 1'b1;
    end

    // Tag and data are qualified by valid, so they are left unreset.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign match_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/instr_cache.sv
// instr_cache: 8-set direct-mapped instruction cache, 16-byte blocks, zero-wait hits, blocking refill FSM.
// Define INSTR_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  address,
    input  logic               read,
    output logic [WORD_W-1:0]  instruction,
    output logic               busywait,
    output logic               mem_read,
    output logic [BADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
`ifdef INSTR_CACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    state_e             state_q, state_d;
    logic [BADDR_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0]  instr_q;
    logic               match, hit;
    logic [BLOCK_W-1:0] rd_data;
    logic [WORD_W-1:0]  rd_word;
    logic               unused_ok;

    instr_cache_array u_array (
        .CLK       (CLK),
        .RESET     (RESET),
        .rd_idx_i  (address[IDX_LSB +: IDX_W]),
        .rd_tag_i  (address[TAG_LSB +: TAG_W]),
        .match_o   (match),
        .rd_data_o (rd_data),
        .we_i      (state_q == UPDATE),
        .wr_idx_i  (blk_q[IDX_W-1:0]),
        .wr_tag_i  (blk_q[BADDR_W-1:IDX_W]),
        .wr_data_i (fill_q)
    );

    // Byte offset within the word never affects a word fetch.
    assign unused_ok   = ^address[WSEL_LSB-1:0];
    assign hit         = read && match;
    assign rd_word     = sel_word(rd_data, address[WSEL_LSB +: WSEL_W]);
    assign instruction = hit ? rd_word : instr_q;
    assign busywait    = RESET && read && !hit;
    assign mem_read    = (state_q == MEM_READ);
    assign mem_address = blk_q;

    // Next state: miss starts a fill of the latched block, memory completion captures it, one write cycle.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (read && !hit) begin
                    state_d = MEM_READ;
                    blk_d   = address[ADDR_W-1:IDX_LSB];
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    state_d = UPDATE;
                    fill_d  = mem_readdata;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and the last served word, both cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instruction;
        end
    end

    // Latched fill address and captured block need no reset: only used once a fill has started.
    always_ff @(posedge CLK) begin
        blk_q  <= blk_d;
        fill_q <= fill_d;
    end

`ifdef INSTR_CACHE_STATS_EN
    logic [15:0] hit_q, miss_q;

    // Saturating counters: hits counted per IDLE hit cycle, misses per fill start.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (state_q == IDLE && hit && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            if (state_q == IDLE && read && !hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: randomized scoreboard bench for instr_cache against a simple set/tag reference model
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [9:0]   address = '0;
    logic         read = 1'b0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b1;
`ifdef INSTR_CACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .address      (address),
        .read         (read),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef INSTR_CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        bit          chk_stall;
    } exp_t;

    int          checks = 0, passed = 0;
    int          lat = 5, served = 0, stall = 0, mcnt = 0;
    int          model_hits = 0, model_misses = 0;
    bit          mvalid [8];
    int          mtag [8];
    logic [31:0] last_exp = '0;
    exp_t        sb [$];
    logic [5:0]  blkq [$];
    logic [5:0]  cur_blk = '0;
    bit          prev_mr = 1'b0, sat_mode = 1'b0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instruction memory content: a fixed scramble of block number and word number.
    function automatic logic [31:0] mem_word(input logic [5:0] b, input logic [1:0] w);
        return (32'(b) * 32'h9E37_79B1) ^ (32'(w) * 32'h85EB_CA77) ^ 32'h1234_5678;
    endfunction

    // Reference model: direct-mapped lookup by plain address arithmetic, installs on miss.
    function automatic exp_t predict(input logic [9:0] a);
        exp_t e;
        int   blk, idx, tg, w;
        blk = int'(a) / 16;
        idx = blk % 8;
        tg  = int'(a) / 128;
        w   = (int'(a) / 4) % 4;
        e.instr     = mem_word(6'(blk), 2'(w));
        e.chk_stall = 1'b1;
        if (mvalid[idx] && mtag[idx] == tg) e.stall = 0;
        else begin
            e.stall     = lat + 2;
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            blkq.push_back(6'(blk));
            model_misses++;
        end
        return e;
    endfunction

    task automatic wait_served(input int target);
        for (int n = 0; n < 200 && served != target; n++) begin
            @(posedge CLK); #1;
        end
        if (served != target) begin
            check("fetch_timeout", 32'(served), 32'(target));
            sb.delete();
            read = 1'b0;
        end
    endtask

    task automatic fetch(input logic [9:0] a, input int l);
        int target;
        lat = l;
        sb.push_back(predict(a));
        model_hits++;
        target  = served + 1;
        address = a;
        read    = 1'b1;
        wait_served(target);
    endtask

    task automatic idle(input int n);
        read    = 1'b0;
        address = 10'($urandom_range(0, 1023));
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Memory responder: mem_busywait goes low for one cycle after `lat` cycles of mem_read.
    always @(negedge CLK) begin
        if (mem_read) begin
            mcnt++;
            if (mcnt >= lat) begin
                mem_busywait = 1'b0;
                for (int w = 0; w < 4; w++) mem_readdata[32*w +: 32] = mem_word(mem_address, 2'(w));
            end else begin
                mem_busywait = 1'b1;
                mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end else begin
            mcnt         = 0;
            mem_busywait = 1'b1;
            mem_readdata = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Monitor: checks fill addresses, pops the scoreboard on every served fetch, checks idle behaviour.
    always @(negedge CLK) begin
        if (!RESET) begin
            stall   = 0;
            prev_mr = 1'b0;
        end else begin
            if (mem_read) begin
                if (!prev_mr) begin
                    check("fill_expected", 32'(blkq.size() > 0), 32'd1);
                    if (blkq.size() > 0) cur_blk = blkq.pop_front();
                end
                check("mem_address", 32'(mem_address), 32'(cur_blk));
            end
            prev_mr = mem_read;
            if (read && busywait) stall++;
            else if (read && !sat_mode) begin
                check("serve_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("instruction", instruction, mon_e.instr);
                    if (mon_e.chk_stall) check("stall_cycles", 32'(stall), 32'(mon_e.stall));
                    last_exp = mon_e.instr;
                end
                stall = 0;
                served++;
            end else if (!read) begin
                check("idle_busywait", 32'(busywait), 32'd0);
                check("idle_hold", instruction, last_exp);
                check("idle_mem_read", 32'(mem_read), 32'(mem_read && prev_mr));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a, b, last_a;
        exp_t       e;
        int         target;
        foreach (mvalid[i]) begin mvalid[i] = 1'b0; mtag[i] = 0; end
        #1;
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        idle(2);

        // Cold fill, sequential hits, same-index eviction.
        fetch(10'h000, 5);
        fetch(10'h004, 5);
        fetch(10'h008, 5);
        fetch(10'h00C, 5);
        fetch(10'h080, 3);
        fetch(10'h000, 4);
        idle(3);

        // Reset in the middle of a fill abandons it.
        lat = 6;
        a   = 10'h140;
        void'(predict(a));
        address = a;
        read    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("mid_fill_mem_read", 32'(mem_read), 32'd1);
        RESET = 1'b0;
        #1;
        check("rst_fill_mem_read", 32'(mem_read), 32'd0);
        check("rst_fill_busywait", 32'(busywait), 32'd0);
        check("rst_fill_instruction", instruction, 32'd0);
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        blkq.delete();
        last_exp     = '0;
        model_hits   = 0;
        model_misses = 0;
        read         = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        idle(2);
        fetch(a, 2);

        // Address changed mid-miss: latched block is filled, new index still misses afterwards.
        lat = 4;
        a   = 10'h010;
        b   = 10'h3A8;
        void'(predict(a));
        e = predict(b);
        e.chk_stall = 1'b0;
        sb.push_back(e);
        model_hits++;
        target  = served + 1;
        address = a;
        read    = 1'b1;
        repeat (2) @(posedge CLK);
        #1 address = b;
        wait_served(target);
        fetch(a, 4);
        idle(1);

        // Random traffic biased toward block reuse.
        last_a = 10'h000;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) a = (last_a & 10'h3F0) | 10'(4 * $urandom_range(0, 3));
            else a = 10'($urandom_range(0, 1023));
            fetch(a, int'($urandom_range(1, 6)));
            last_a = a;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

`ifdef INSTR_CACHE_STATS_EN
        check("hit_count", 32'(hit_count), 32'(model_hits));
        check("miss_count", 32'(miss_count), 32'(model_misses));
        fetch(10'h000, 2);
        sat_mode = 1'b1;
        address  = 10'h000;
        read     = 1'b1;
        repeat (65600) @(posedge CLK);
        #1;
        check("hit_count_sat", 32'(hit_count), 32'h0000_FFFF);
        check("miss_count_steady", 32'(miss_count), 32'(model_misses));
        read = 1'b0;
        RESET = 1'b0;
        #1;
        check("hit_count_rst", 32'(hit_count), 32'd0);
        check("miss_count_rst", 32'(miss_count), 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b1;
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("fills_drained", 32'(blkq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 The block SHALL have no parameters; the geometry is fixed at 8 sets, direct-mapped, 16-byte blocks, 10-bit byte address.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 address  input  10  CPU fetch byte address (PC[9:0]).
REQ-005 read  input  1  CPU fetch request.
REQ-006 instruction  output  32  fetched instruction word.
REQ-007 busywait  output  1  stall to the CPU; high while the fetch is unserved.
REQ-008 mem_read  output  1  block read request to the instruction memory.
REQ-009 mem_address  output  6  block address to the memory (address[9:4]).
REQ-010 mem_readdata  input  128  returned block; word0 occupies bits 31:0.
REQ-011 mem_busywait  input  1  memory busy; low for exactly one cycle marks mem_readdata valid.

Function
REQ-012 Address split SHALL be: tag = [9:7], index = [6:4], word = [3:2]; bits [1:0] SHALL be ignored.
REQ-013 hit SHALL be read && valid[index] && tag_store[index]==tag, evaluated combinationally.
REQ-014 On a hit, instruction SHALL present the selected word and busywait SHALL be 0 in the same cycle (zero-wait fetch).
REQ-015 On a miss, busywait SHALL rise combinationally in the same cycle and stay high until the cycle the refetch hits.
REQ-016 The FSM SHALL have three states: IDLE, MEM_READ, UPDATE.
REQ-017 IDLE->MEM_READ on read && !hit; the block address SHALL be latched at that edge.
REQ-018 In MEM_READ, mem_read SHALL be 1 and mem_address SHALL be the latched block address; the FSM SHALL stay until it samples mem_busywait==0, then capture mem_readdata and go to UPDATE.
REQ-019 UPDATE SHALL write data, tag and valid=1 at the latched index in one cycle, then return to IDLE; the lookup SHALL then hit and drop busywait.
REQ-020 A miss SHALL therefore cost memory latency + 2 cycles.
REQ-021 If read falls or address changes during MEM_READ/UPDATE, the fill SHALL complete using the latched address.
REQ-022 When read==0, busywait SHALL be 0 and instruction SHALL hold its last value.
REQ-023 mem_read SHALL be 0 in IDLE and UPDATE.

Reset
REQ-024 RESET low SHALL immediately clear every valid bit, force IDLE, and drive mem_read=0, busywait=0 and instruction=0.
REQ-025 A reset during MEM_READ SHALL abandon the fill; the next request after reset SHALL miss.
REQ-026 The data and tag arrays SHALL NOT require reset.

Configuration
REQ-027 With INSTR_CACHE_STATS_EN defined, the block SHALL add outputs hit_count[15:0] and miss_count[15:0].
REQ-028 hit_count SHALL increment on each IDLE cycle with a hit; miss_count SHALL increment on each IDLE->MEM_READ transition; both SHALL saturate at 16'hFFFF and clear on reset.
REQ-029 Without INSTR_CACHE_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package instr_cache_pkg SHALL hold the address field widths and positions, the block width (128) and the FSM state encoding.
REQ-031 Storage (valid, tag, data arrays with lookup and write port) SHALL be the sub-module instr_cache_array; the FSM and muxing SHALL stay in instr_cache.

Verification
REQ-032 Cold fetch at 0x000 with a 5-cycle memory -> busywait high for 7 cycles, mem_address=0, then instruction = word0 of the block.
REQ-033 Sequential fetch of 0x004, 0x008, 0x00C after the fill -> each hits, busywait stays 0, and the outputs are words 1 to 3.
REQ-034 Fetch 0x000 then 0x080 (same index, tag 1) and back to 0x000 -> three misses, with the second fill evicting the first.
REQ-035 Assert RESET during MEM_READ -> mem_read drops immediately, and a re-request to the same address misses again.
REQ-036 Address toggled mid-miss -> the fill uses the latched address, and the block at the new index remains invalid.
REQ-037 With INSTR_CACHE_STATS_EN, the above sequence -> counts match the expected hits/misses, and saturation holds at 16'hFFFF.
